// File: rtl/line_buffer_wr_ctrl_pkg.sv
// Shared types and defaults for the line buffer write-side sequencer.
package line_buffer_pkg;

  localparam int NCH_DEF = 16;
  localparam int DW_DEF  = 32;
  localparam int AW_DEF  = 32;
  localparam int DEPTH_W = 16;

  // Sequencer state, also exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_WR   = 2'd2
  } lb_state_e;

endpackage

// File: rtl/line_buffer_wr_ctrl_if.sv
// RAM write port of the line buffer.
// Handshake: the master raises ram_wr_en and holds ram_wr_addr/ram_wr_data
// stable; the write is accepted on a rising pclk edge where ram_wr_en and
// ram_wr_rdy are both 1. ram_wr_rdy may depend on nothing but the RAM side.
interface line_buffer_wr_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 32
) ();

  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_wr_rdy;

  modport master (
    output ram_wr_en,
    output ram_wr_addr,
    output ram_wr_data,
    input  ram_wr_rdy
  );

  modport slave (
    input  ram_wr_en,
    input  ram_wr_addr,
    input  ram_wr_data,
    output ram_wr_rdy
  );

endinterface

// File: rtl/line_buffer_wr_ctrl_arb.sv
// Round-robin priority picker: first eligible channel above last_grant,
// wrapping modulo NCH. Purely combinational; the caller owns last_grant.
module lb_rr_arb #(
  parameter int NCH = 16,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] elig,
  input  logic [IW-1:0]  last_grant,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx,
  output logic           valid
);

  logic [IW-1:0] cand;

  // Scan from the farthest candidate down so the nearest one wins last.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % NCH);
      if (elig[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/line_buffer_wr_ctrl.sv
// Write-side sequencer for the line buffer RAM: round-robin shares one RAM
// write port between NCH channels and generates per-channel line addresses.
// Optional overflow flagging is built when LINE_BUFFER_WR_CTRL_OVF_CHK_EN
// is defined; otherwise ovf_err is tied low and pointers wrap silently.
module line_buffer_wr_ctrl
  import line_buffer_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 cfg_input_enable,
  input  logic                 cfg_fe_offset_lock,
  input  logic [DEPTH_W-1:0]   cfg_real_depth,
  input  logic [AW-1:0]        cfg_ram_base,
  input  logic [AW-1:0]        cfg_ram_base_offset,
  input  logic [NCH-1:0]       cfg_actived_chnl,
  input  logic [NCH-1:0]       ch_req,
  input  logic [NCH-1:0]       ch_last,
  input  logic [NCH*DW-1:0]    ch_data,
  output logic [NCH-1:0]       ch_gnt,
  line_buffer_wr_ctrl_if.master wr,
  output logic [NCH-1:0]       line_done,
  output logic [NCH-1:0]       ovf_err,
  output logic                 busy,
  output lb_state_e            dbg_state
);

  localparam int IW = $clog2(NCH);

  lb_state_e          state_q, state_d;
  logic [IW-1:0]      last_grant_q, idx_q;
  logic [DW-1:0]      data_q;
  logic               last_q;
  logic [AW-1:0]      addr_q;
  logic [NCH-1:0]     gnt_q, done_q;
  logic               busy_q;
  logic [AW-1:0]      sh_base_q, sh_off_q;
  logic [DEPTH_W-1:0] ptr_q [NCH];

  logic [NCH-1:0]     elig, arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;
  logic               pick, accept, line_end;
  logic [DEPTH_W-1:0] depth_m1, cur_ptr, pick_ptr;
  logic [AW-1:0]      pick_addr;

  assign elig = ch_req & cfg_actived_chnl;

  lb_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
    .elig       (elig),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt),
    .idx        (arb_idx),
    .valid      (arb_valid)
  );

  // Depth 0 encodes 65536, which the 16-bit subtraction gives for free.
  assign depth_m1  = cfg_real_depth - DEPTH_W'(1);
  assign pick      = (state_q == ST_ARB) && cfg_input_enable && arb_valid;
  assign accept    = (state_q == ST_WR) && wr.ram_wr_rdy;
  assign cur_ptr   = ptr_q[idx_q];
  assign line_end  = last_q || (cur_ptr == depth_m1);
  assign pick_ptr  = ptr_q[arb_idx];
  // Stride multiply is truncated to AW bits; the sum wraps modulo 2^AW.
  assign pick_addr = sh_base_q + AW'(sh_off_q * AW'(arb_idx)) + AW'(pick_ptr);

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode; a write in progress always completes before disable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cfg_input_enable) state_d = ST_ARB;
      ST_ARB: begin
        if (!cfg_input_enable) state_d = ST_IDLE;
        else if (arb_valid)    state_d = ST_WR;
      end
      ST_WR:   if (wr.ram_wr_rdy) state_d = ST_ARB;
      default: state_d = ST_IDLE;
    endcase
  end

  // Captured word, grant/done pulses, shadow config and round-robin pointer.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      last_grant_q <= IW'(NCH - 1);
      idx_q        <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      addr_q       <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      sh_base_q    <= '0;
      sh_off_q     <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      busy_q <= (state_d != ST_IDLE);
      if ((state_q == ST_IDLE) && !cfg_fe_offset_lock) begin
        sh_base_q <= cfg_ram_base;
        sh_off_q  <= cfg_ram_base_offset;
      end
      if (pick) begin
        idx_q  <= arb_idx;
        data_q <= ch_data[arb_idx*DW +: DW];
        last_q <= ch_last[arb_idx];
        addr_q <= pick_addr;
        gnt_q  <= arb_gnt;
      end
      if (accept) begin
        last_grant_q <= idx_q;
        if (line_end) done_q[idx_q] <= 1'b1;
      end
    end
  end

  // Per-channel line pointers: held at zero while idle, advanced on accept.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < NCH; i++) ptr_q[i] <= '0;
    end else if (state_q == ST_IDLE) begin
      for (int i = 0; i < NCH; i++) ptr_q[i] <= '0;
    end else if (accept) begin
      ptr_q[idx_q] <= line_end ? '0 : cur_ptr + DEPTH_W'(1);
    end
  end

`ifdef LINE_BUFFER_WR_CTRL_OVF_CHK_EN
  logic [NCH-1:0] ovf_q;

  // Sticky overflow: line filled to depth without a last flag.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ovf_q <= '0;
    end else if ((state_q == ST_ARB) && !cfg_input_enable) begin
      ovf_q <= '0;
    end else if (accept && !last_q && (cur_ptr == depth_m1)) begin
      ovf_q[idx_q] <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = '0;
`endif

  assign ch_gnt         = gnt_q;
  assign wr.ram_wr_en   = (state_q == ST_WR);
  assign wr.ram_wr_addr = addr_q;
  assign wr.ram_wr_data = data_q;
  assign line_done      = done_q;
  assign busy           = busy_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_line_buffer_wr_ctrl.sv
// Bench for line_buffer_wr_ctrl: per-channel word queues drive requests,
// a transaction-level model predicts grants, addresses, line completion
// and overflow each cycle. Honours LINE_BUFFER_WR_CTRL_OVF_CHK_EN.
`timescale 1ns/1ps
module tb_line_buffer_wr_ctrl;
  import line_buffer_pkg::*;

  localparam int NCH  = 16;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXW = 256;
`ifdef LINE_BUFFER_WR_CTRL_OVF_CHK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              pclk = 1'b0;
  logic              presetn = 1'b0;
  logic              cfg_input_enable, cfg_fe_offset_lock;
  logic [15:0]       cfg_real_depth;
  logic [AW-1:0]     cfg_ram_base, cfg_ram_base_offset;
  logic [NCH-1:0]    cfg_actived_chnl, ch_req, ch_last;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_gnt, line_done, ovf_err;
  logic              busy;
  lb_state_e         dbg_state;

  line_buffer_wr_ctrl_if #(.DW(DW), .AW(AW)) wr_if ();

  line_buffer_wr_ctrl #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
    .pclk                (pclk),
    .presetn             (presetn),
    .cfg_input_enable    (cfg_input_enable),
    .cfg_fe_offset_lock  (cfg_fe_offset_lock),
    .cfg_real_depth      (cfg_real_depth),
    .cfg_ram_base        (cfg_ram_base),
    .cfg_ram_base_offset (cfg_ram_base_offset),
    .cfg_actived_chnl    (cfg_actived_chnl),
    .ch_req              (ch_req),
    .ch_last             (ch_last),
    .ch_data             (ch_data),
    .ch_gnt              (ch_gnt),
    .wr                  (wr_if.master),
    .line_done           (line_done),
    .ovf_err             (ovf_err),
    .busy                (busy),
    .dbg_state           (dbg_state)
  );

  always #5 pclk = ~pclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- stimulus state ----------------
  logic          set_en, set_lock;
  logic [15:0]   set_depth;
  logic [AW-1:0] set_base, set_off;
  logic [NCH-1:0] set_mask;
  int rdy_pct, rdy_block, enq_pct, last_pct;

  logic [DW:0] wmem [NCH][MAXW];
  int wcnt [NCH];
  int wrd  [NCH];

  // ---------------- reference model ----------------
  typedef enum int {P_IDLE, P_ARB, P_WR} phase_t;
  phase_t          phase;
  int              ptr_m [NCH];
  int              lastg, cur_ch;
  bit              cur_last;
  longint          sh_base, sh_off;
  logic [NCH-1:0]  exp_gnt, exp_done, exp_ovf;
  logic [AW+DW-1:0] exp_q [$];

  int             grant_log [$];
  logic [AW-1:0]  acc_log [$];
  int             done_cnt [NCH];
  int             wr_cnt, gnt_cnt;

  function automatic void enq(int ch, logic [DW-1:0] d, bit l);
    if (wcnt[ch] < MAXW) begin
      wmem[ch][wcnt[ch]] = {l, d};
      wcnt[ch]++;
    end
  endfunction

  function automatic void flush_words();
    for (int i = 0; i < NCH; i++) begin
      wcnt[i] = 0;
      wrd[i]  = 0;
    end
  endfunction

  function automatic logic [NCH-1:0] has_words();
    logic [NCH-1:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = (wrd[i] < wcnt[i]);
    return v;
  endfunction

  function automatic int rr_pick(logic [NCH-1:0] e, int last);
    for (int k = 1; k <= NCH; k++) begin
      if (e[(last + k) % NCH]) return (last + k) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] m_addr(int ch);
    longint a;
    a = sh_base + longint'(ch) * sh_off + longint'(ptr_m[ch]);
    return AW'(a);
  endfunction

  function automatic void mdl_reset();
    phase    = P_IDLE;
    lastg    = NCH - 1;
    cur_ch   = 0;
    cur_last = 1'b0;
    sh_base  = 0;
    sh_off   = 0;
    exp_gnt  = '0;
    exp_done = '0;
    exp_ovf  = '0;
    exp_q.delete();
    for (int i = 0; i < NCH; i++) ptr_m[i] = 0;
  endfunction

  // Compare the DUT against what the model predicted for this cycle.
  task automatic check_cycle();
    check_eq("ch_gnt", ch_gnt, exp_gnt);
    check_eq("ram_wr_en", wr_if.ram_wr_en, phase == P_WR);
    check_eq("busy", busy, phase != P_IDLE);
    check_eq("line_done", line_done, exp_done);
    check_eq("ovf_err", ovf_err, exp_ovf);
    if (phase == P_WR && exp_q.size() > 0)
      check_eq("wr_addr_data", {wr_if.ram_wr_addr, wr_if.ram_wr_data}, exp_q[0]);
    for (int i = 0; i < NCH; i++) begin
      if (line_done[i]) done_cnt[i]++;
      if (ch_gnt[i]) grant_log.push_back(i);
    end
    if (wr_if.ram_wr_en) wr_cnt++;
    if (ch_gnt != '0) gnt_cnt++;
  endtask

  // Requesters, config and RAM ready for the coming cycle.
  task automatic drive();
    for (int i = 0; i < NCH; i++)
      if (ch_gnt[i] && wrd[i] < wcnt[i]) wrd[i]++;
    if (enq_pct > 0)
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(99) < enq_pct) enq(i, $urandom, $urandom_range(99) < last_pct);
    for (int i = 0; i < NCH; i++) begin
      ch_req[i] = (wrd[i] < wcnt[i]);
      if (ch_req[i]) {ch_last[i], ch_data[i*DW +: DW]} = wmem[i][wrd[i]];
      else           {ch_last[i], ch_data[i*DW +: DW]} = '0;
    end
    cfg_input_enable    = set_en;
    cfg_fe_offset_lock  = set_lock;
    cfg_real_depth      = set_depth;
    cfg_ram_base        = set_base;
    cfg_ram_base_offset = set_off;
    cfg_actived_chnl    = set_mask;
    if (phase == P_WR && rdy_block > 0) begin
      wr_if.ram_wr_rdy = 1'b0;
      rdy_block--;
    end else begin
      wr_if.ram_wr_rdy = ($urandom_range(99) < rdy_pct);
    end
    if (wr_if.ram_wr_en && wr_if.ram_wr_rdy) acc_log.push_back(wr_if.ram_wr_addr);
  endtask

  // Advance the model over the coming clock edge.
  task automatic predict();
    logic [NCH-1:0] elig;
    int c, depth;
    elig     = ch_req & cfg_actived_chnl;
    exp_gnt  = '0;
    exp_done = '0;
    case (phase)
      P_IDLE: begin
        for (int i = 0; i < NCH; i++) ptr_m[i] = 0;
        if (!cfg_fe_offset_lock) begin
          sh_base = cfg_ram_base;
          sh_off  = cfg_ram_base_offset;
        end
        if (cfg_input_enable) phase = P_ARB;
      end
      P_ARB: begin
        if (!cfg_input_enable) begin
          phase   = P_IDLE;
          exp_ovf = '0;
        end else begin
          c = rr_pick(elig, lastg);
          if (c >= 0) begin
            exp_gnt[c] = 1'b1;
            exp_q.push_back({m_addr(c), ch_data[c*DW +: DW]});
            cur_ch   = c;
            cur_last = ch_last[c];
            phase    = P_WR;
          end
        end
      end
      default: begin
        if (wr_if.ram_wr_rdy) begin
          depth = (cfg_real_depth == 16'd0) ? 65536 : int'(cfg_real_depth);
          void'(exp_q.pop_front());
          if (cur_last || ptr_m[cur_ch] + 1 == depth) begin
            if (OVF_EN && !cur_last) exp_ovf[cur_ch] = 1'b1;
            ptr_m[cur_ch]    = 0;
            exp_done[cur_ch] = 1'b1;
          end else begin
            ptr_m[cur_ch]++;
          end
          lastg = cur_ch;
          phase = P_ARB;
        end
      end
    endcase
  endtask

  task automatic step();
    @(negedge pclk);
    check_cycle();
    drive();
    predict();
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    #1;
    check_eq("rst_ch_gnt", ch_gnt, 0);
    check_eq("rst_wr_en", wr_if.ram_wr_en, 0);
    check_eq("rst_wr_addr", wr_if.ram_wr_addr, 0);
    check_eq("rst_wr_data", wr_if.ram_wr_data, 0);
    check_eq("rst_line_done", line_done, 0);
    check_eq("rst_ovf_err", ovf_err, 0);
    check_eq("rst_busy", busy, 0);
    mdl_reset();
    @(negedge pclk);
    presetn = 1'b1;
    check_cycle();
    drive();
    predict();
  endtask

  task automatic wait_wr(input int budget);
    int n = 0;
    while (phase != P_WR && n < budget) begin
      step();
      n++;
    end
    check_eq("wait_wr_timeout", phase == P_WR, 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((((has_words() & set_mask) != '0) || phase == P_WR) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_timeout", n < budget, 1);
    repeat (3) step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    set_en = 1'b0; set_lock = 1'b0; set_depth = 16'd4;
    set_base = 32'h100; set_off = 32'h40; set_mask = 16'h0001;
    rdy_pct = 100; rdy_block = 0; enq_pct = 0; last_pct = 0;
    cfg_input_enable = 1'b0; cfg_fe_offset_lock = 1'b0; cfg_real_depth = 16'd4;
    cfg_ram_base = '0; cfg_ram_base_offset = '0; cfg_actived_chnl = '0;
    ch_req = '0; ch_last = '0; ch_data = '0;
    wr_if.ram_wr_rdy = 1'b0;
    wr_cnt = 0; gnt_cnt = 0;
    for (int i = 0; i < NCH; i++) done_cnt[i] = 0;
    flush_words();
    mdl_reset();
    repeat (3) @(negedge pclk);
    do_reset();

    // Basic write: one line of four words on ch0.
    for (int k = 0; k < 4; k++) enq(0, 32'hA000 + k, k == 3);
    set_en = 1'b1;
    drain(200);
    check_eq("basic_done_cnt", done_cnt[0], 1);
    for (int k = 0; k < 4; k++)
      check_eq("basic_addr", (acc_log.size() > k) ? acc_log[k] : 'x, 32'h100 + k);
    enq(0, 32'hA0FF, 1'b1);
    drain(50);
    check_eq("basic_ptr_wrapped", (acc_log.size() > 4) ? acc_log[4] : 'x, 32'h100);

    // Round robin across four channels from a fresh arbiter.
    do_reset();
    set_mask = 16'h000F;
    grant_log.delete(); acc_log.delete();
    for (int k = 0; k < 3; k++)
      for (int ch = 0; ch < 4; ch++) enq(ch, $urandom, k == 2);
    drain(200);
    for (int k = 0; k < 5; k++)
      check_eq("rr_order", (grant_log.size() > k) ? grant_log[k] : -1, k % 4);
    check_eq("rr_ch2_addr", (acc_log.size() > 2) ? acc_log[2] : 'x, 32'h180);

    // Backpressure: ready held low for five WR cycles.
    set_mask = 16'h0001;
    wr_cnt = 0; gnt_cnt = 0;
    rdy_block = 5;
    enq(0, 32'hBEEF0001, 1'b0);
    drain(100);
    check_eq("bp_wr_cycles", wr_cnt, 6);
    check_eq("bp_gnt_pulses", gnt_cnt, 1);

    // Overflow: depth 2, three words on ch1 with no last.
    set_depth = 16'd2;
    set_mask  = 16'h0002;
    acc_log.delete();
    for (int k = 0; k < 3; k++) enq(1, 32'hC000 + k, 1'b0);
    drain(100);
    check_eq("ovf_flag", ovf_err[1], OVF_EN);
    check_eq("ovf_third_addr", (acc_log.size() > 2) ? acc_log[2] : 'x, 32'h140);
    set_en = 1'b0;
    repeat (3) step();
    check_eq("ovf_cleared_idle", ovf_err, 0);

    // Disable mid-write with the shadow copies locked.
    set_depth = 16'd8;
    set_mask  = 16'h0001;
    set_en    = 1'b1;
    rdy_block = 3;
    enq(0, 32'hD0000001, 1'b0);
    wait_wr(50);
    set_lock = 1'b1;
    set_base = 32'h800;
    set_en   = 1'b0;
    repeat (8) step();
    check_eq("dis_busy_low", busy, 0);
    acc_log.delete();
    set_en = 1'b1;
    enq(0, 32'hD0000002, 1'b0);
    drain(50);
    check_eq("lock_old_base", (acc_log.size() > 0) ? acc_log[0] : 'x, 32'h100);
    set_en = 1'b0;
    repeat (3) step();
    set_lock = 1'b0;
    repeat (2) step();
    acc_log.delete();
    set_en = 1'b1;
    enq(0, 32'hD0000003, 1'b0);
    drain(50);
    check_eq("unlock_new_base", (acc_log.size() > 0) ? acc_log[0] : 'x, 32'h800);

    // Randomised traffic with changing masks and a disable window.
    set_en = 1'b0;
    repeat (3) step();
    flush_words();
    set_depth = 16'($urandom_range(2, 6));
    set_en    = 1'b1;
    enq_pct = 2; last_pct = 30; rdy_pct = 60;
    for (int n = 0; n < 1200; n++) begin
      if (n % 150 == 0) set_mask = NCH'($urandom) | NCH'(1);
      if (n == 600) set_en = 1'b0;
      if (n == 606) set_en = 1'b1;
      step();
    end
    enq_pct = 0;
    drain(4000);
    rdy_pct = 100;
    flush_words();

    // Asynchronous reset in the middle of a write.
    set_mask = 16'h000F;
    for (int k = 0; k < 3; k++)
      for (int ch = 0; ch < 4; ch++) enq(ch, $urandom, 1'b0);
    rdy_block = 3;
    wait_wr(50);
    step();
    do_reset();
    grant_log.delete(); acc_log.delete();
    drain(300);
    check_eq("rst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    check_eq("rst_first_addr", (acc_log.size() > 0) ? acc_log[0] : 'x, 32'h800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_wr_ctrl.md
# line_buffer_wr_ctrl

Write-side sequencer for the line buffer RAM. It shares one RAM write port between up to NCH pixel-channel requesters using round-robin arbitration, over channels enabled in `cfg_actived_chnl`. It generates per-channel line addresses from the base, offset and depth fields in the line buffer register block, and reports line completion and overflow. It sits between the channel front-ends and the line RAM, on the APB clock domain.

## Interface
- NCH, 16, number of requesting channels (matches width of `cfg_actived_chnl`)
- DW, 32, write data width
- AW, 32, RAM address width (word addressed)
- pclk  in  1  clock
- presetn  in  1  reset; one clock; reset is asynchronous and active-low
- cfg_input_enable  in  1  global enable for the controller
- cfg_fe_offset_lock  in  1  1 = freeze the shadow copies of base/offset
- cfg_real_depth  in  16  line length in words; 0 means 65536
- cfg_ram_base  in  32  RAM base word address
- cfg_ram_base_offset  in  32  per-channel address stride in words
- cfg_actived_chnl  in  NCH  per-channel enable mask
- ch_req  in  NCH  request: channel has a word ready
- ch_last  in  NCH  qualifies the word as the last of its line
- ch_data  in  NCH*DW  channel data; channel i occupies bits [i*DW +: DW]
- ch_gnt  out  NCH  one-hot, one-cycle pulse: word consumed
- ram_wr_en  out  1  RAM write request
- ram_wr_addr  out  AW  write address
- ram_wr_data  out  DW  write data
- ram_wr_rdy  in  1  RAM accepts the write this cycle
- line_done  out  NCH  one-cycle pulse when a channel's line closes
- ovf_err  out  NCH  sticky flag: line exceeded depth
- busy  out  1  controller is not in IDLE

## Operation
- **FSM IDLE / ARB / WR.** Reset state is IDLE.
- **IDLE**
  - All per-channel write pointers are held at 0.
  - Shadow base/offset registers load from cfg each cycle while `cfg_fe_offset_lock` = 0.
  - Goes to ARB when `cfg_input_enable` = 1.
- **ARB**
  - If `cfg_input_enable` = 0, go to IDLE.
  - Otherwise the eligible set is `ch_req & cfg_actived_chnl`. Pick the first set bit searching upward from last_grant+1, wrapping modulo NCH.
  - On a pick, register the channel index, data, last flag and address, then go to WR.
  - If nothing is eligible, stay in ARB.
- **WR**
  - `ram_wr_en` = 1, and `ch_gnt[idx]` = 1 on the first WR cycle only.
  - Hold addr and data stable until `ram_wr_rdy`. When `ram_wr_rdy` = 1:
    - update the pointer;
    - set last_grant = idx;
    - go to ARB.
  - `cfg_input_enable` falling during WR does not abort the write: it completes, then ARB goes to IDLE.
- **Address:** `ram_wr_addr` = shadow_base + idx*shadow_offset + ptr[idx], computed modulo 2^AW; the multiply is truncated to AW bits.
- **Pointer update on accept**
  - If ch_last = 1, or ptr = depth-1: ptr ← 0 and `line_done[idx]` pulses in the following cycle.
  - Otherwise ptr ← ptr+1.
- **Overflow:** ptr reaching depth-1 without ch_last counts as an overflow (see Configuration).
- **Mask changes:** clearing a `cfg_actived_chnl` bit stops new grants to that channel. Its pointer is retained, and any in-flight write completes.
- **Shadow lock:** the shadow copies are frozen while lock = 1, and also outside IDLE.
- **Reset mid-operation:** all state returns to reset values immediately, including pointers and the in-flight write, which is dropped.

## Timing
- Reset values: `ch_gnt` 0, `ram_wr_en` 0, `ram_wr_addr` 0, `ram_wr_data` 0, `line_done` 0, `ovf_err` 0, `busy` 0, last_grant NCH-1 (so channel 0 wins first).
- Request sampled in ARB at cycle t. `ram_wr_en` and `ch_gnt` are high at t+1, and the earliest accept is t+1.
- Peak throughput is 1 word per 2 cycles.
- Requesters hold `ch_req`, `ch_data` and `ch_last` stable until they see `ch_gnt`. After the grant pulse they may advance their data.
- `line_done` is registered and pulses for 1 cycle, one cycle after the accept.
- `busy` is a registered decode of state ≠ IDLE.

## Configuration
- Macro: `LINE_BUFFER_WR_CTRL_OVF_CHK_EN`.
- **Defined:** an accept with ptr = depth-1 and ch_last = 0 sets `ovf_err[idx]`. The flag is sticky and cleared only by reset or by IDLE entry. The pointer still wraps to 0 and `line_done` still pulses.
- **Undefined:** `ovf_err` is tied to 0, no overflow logic is built, and the pointer wraps silently.

## Structure
- Package `line_buffer_pkg`:
  - FSM state enum (IDLE/ARB/WR);
  - defaults for NCH, DW, AW;
  - DEPTH_W = 16.
- Sub-module `lb_rr_arb`: NCH-wide round-robin priority picker.
  - Inputs: eligible mask, last_grant.
  - Outputs: one-hot grant, index, valid.
  - Purely combinational. The controller owns the last_grant register.

## Test plan
- **Basic write:** base=0x100, offset=0x40, depth=4, mask=0x0001; ch0 requests 4 words (last on the 4th) with rdy=1.
  - Addresses 0x100..0x103.
  - `line_done[0]` pulses once, after the 4th accept.
  - ptr returns to 0.
- **Round-robin and addressing:** mask=0x000F, all four channels requesting continuously.
  - Grant order is 0,1,2,3,0.
  - ch2's first address is 0x180.
  - No channel is granted twice while another eligible channel is waiting.
- **Backpressure:** `ram_wr_rdy` held 0 for 5 cycles during WR.
  - addr and data stay stable throughout.
  - `ch_gnt` is high on the first WR cycle only.
  - The accept happens on the cycle rdy rises, followed by a return to ARB.
- **Overflow (macro defined):** depth=2, ch1 sends 3 words with no last.
  - `ovf_err[1]` sets after the 2nd accept.
  - The 3rd word is written to base+offset+0.
- **Disable and lock:** `cfg_input_enable` dropped mid-WR, with lock=1 while `cfg_ram_base` changes.
  - The write completes, then IDLE, with `busy`=0.
  - On re-enable the old base is used until lock=0 in IDLE.
- **Async reset:** `presetn` asserted during WR.
  - All outputs 0 in the same cycle.
  - After release, the next grant goes to ch0 and the address uses ptr=0.
